// File: rtl/lsu_ex.sv
// rtl/lsu_ex.sv - EX-stage load/store unit with two-phase addr_ok/data_ok RAM handshake
//
// Purpose:
//   Runs the data-RAM access of the instruction held in EX. Stores get
//   lane-replicated data and byte strobes. Loads get the selected byte or
//   half, sign- or zero-extended. ready_go_ex holds the pipe until the access
//   completes and WB takes the result.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   flush               kill the instruction in EX
//   valid_ex            EX slot holds a valid instruction
//   mem_read_ex         load in EX
//   mem_write_ex        store in EX
//   funct3_ex           access size/sign
//   addr_ex             effective byte address
//   store_data_ex       store source data
//   allow_in_wb         WB accepts the EX result this cycle
//   ram_req             request valid (ADDR phase)
//   ram_we              request is a write
//   ram_addr            word-aligned request address
//   ram_wdata           lane-replicated store data
//   ram_wstrb           byte enables, 0000 on reads
//   mem_addr_ok         request accepted this cycle
//   mem_data_ok         read data / write ack valid this cycle
//   mem_rdata           raw read word
//   load_data           formatted load result
//   ready_go_ex         EX may hand its result to WB
//   mem_exc_ex          misaligned or illegal access, no request issued
//   lsu_busy            an access is in flight

module lsu_ex (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        valid_ex,
  input  logic        mem_read_ex,
  input  logic        mem_write_ex,
  input  logic [2:0]  funct3_ex,
  input  logic [31:0] addr_ex,
  input  logic [31:0] store_data_ex,
  input  logic        allow_in_wb,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        ready_go_ex,
  output logic        mem_exc_ex,
  output logic        lsu_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_q;
  logic        ram_req_q;
  logic        ram_we_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [3:0]  ram_wstrb_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] load_data_q;

  logic        mem_op;
  logic        bad_f3;
  logic        misalign;
  logic        exc;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_d;

  assign mem_op = valid_ex & (mem_read_ex | mem_write_ex);

  // Illegal encodings: load+store together, stores wider than a word or with
  // the unsigned bit set, and the unused load encodings.
  always_comb begin
    bad_f3 = 1'b0;
    if (mem_read_ex && mem_write_ex) begin
      bad_f3 = 1'b1;
    end else if (mem_write_ex) begin
      bad_f3 = funct3_ex[2] | (funct3_ex[1:0] == 2'b11);
    end else begin
      bad_f3 = (funct3_ex == 3'b011) | (funct3_ex == 3'b110) | (funct3_ex == 3'b111);
    end
  end

  assign misalign = ((funct3_ex[1:0] == 2'b01) &  addr_ex[0]) |
                    ((funct3_ex[1:0] == 2'b10) & (addr_ex[1:0] != 2'b00));

  assign exc = mem_op & (bad_f3 | misalign);

  // Store lane placement; reads latch an all-zero strobe.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = store_data_ex;
    case (funct3_ex[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << addr_ex[1:0];
        wdata_d = {4{store_data_ex[7:0]}};
      end
      2'b01: begin
        wstrb_d = 4'b0011 << addr_ex[1:0];
        wdata_d = {2{store_data_ex[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = store_data_ex;
      end
    endcase
    if (!mem_write_ex) begin
      wstrb_d = 4'b0000;
    end
  end

  // Load formatting uses the latched offset and funct3, since EX inputs may
  // not be trusted while the access is in flight.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_d = {24'd0, ld_byte};
      3'b001:  load_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_d = {16'd0, ld_half};
      default: load_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
      ram_wstrb_q <= 4'd0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      load_data_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op && !exc && !flush) begin
            state_q     <= ADDR;
            ram_req_q   <= 1'b1;
            ram_we_q    <= mem_write_ex;
            ram_addr_q  <= {addr_ex[31:2], 2'b00};
            ram_wdata_q <= wdata_d;
            ram_wstrb_q <= wstrb_d;
            funct3_q    <= funct3_ex;
            off_q       <= addr_ex[1:0];
          end
        end
        ADDR: begin
          // Once accepted the memory owes a data_ok, so a flush in the same
          // cycle must still drain it rather than drop back to IDLE.
          if (mem_addr_ok) begin
            ram_req_q <= 1'b0;
            state_q   <= flush ? DRAIN : DATA;
          end else if (flush) begin
            ram_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            if (!ram_we_q && !flush) begin
              load_data_q <= load_d;
            end
            state_q <= flush ? IDLE : DONE;
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_data_ok) begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (flush || allow_in_wb) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          ram_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_req     = ram_req_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_wstrb   = ram_wstrb_q;
  assign load_data   = load_data_q;
  assign lsu_busy    = (state_q != IDLE);
  assign mem_exc_ex  = (state_q == IDLE) & exc;
  assign ready_go_ex = ((state_q == IDLE) & (~mem_op | exc)) | (state_q == DONE);

endmodule

// File: tb/tb_lsu_ex.sv
// tb/tb_lsu_ex.sv - directed self-checking bench for lsu_ex

module tb_lsu_ex;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid_ex;
  logic        mem_read_ex;
  logic        mem_write_ex;
  logic [2:0]  funct3_ex;
  logic [31:0] addr_ex;
  logic [31:0] store_data_ex;
  logic        allow_in_wb;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        ready_go_ex;
  logic        mem_exc_ex;
  logic        lsu_busy;

  int checks = 0;
  int errors = 0;

  lsu_ex dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .valid_ex      (valid_ex),
    .mem_read_ex   (mem_read_ex),
    .mem_write_ex  (mem_write_ex),
    .funct3_ex     (funct3_ex),
    .addr_ex       (addr_ex),
    .store_data_ex (store_data_ex),
    .allow_in_wb   (allow_in_wb),
    .ram_req       (ram_req),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_wstrb     (ram_wstrb),
    .mem_addr_ok   (mem_addr_ok),
    .mem_data_ok   (mem_data_ok),
    .mem_rdata     (mem_rdata),
    .load_data     (load_data),
    .ready_go_ex   (ready_go_ex),
    .mem_exc_ex    (mem_exc_ex),
    .lsu_busy      (lsu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
    valid_ex      = rd | wr;
    mem_read_ex   = rd;
    mem_write_ex  = wr;
    funct3_ex     = f3;
    addr_ex       = a;
    store_data_ex = sd;
  endtask

  task automatic clr_op();
    valid_ex     = 1'b0;
    mem_read_ex  = 1'b0;
    mem_write_ex = 1'b0;
  endtask

  task automatic zero_wait_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] rd, input logic [31:0] exp);
    cyc();
    set_op(1'b1, 1'b0, f3, a, 32'd0);
    allow_in_wb = 1'b1;
    #1;
    chk({tag, "_c0_ready"}, {31'd0, ready_go_ex}, 32'd0);
    chk({tag, "_c0_req"}, {31'd0, ram_req}, 32'd0);
    cyc();
    mem_addr_ok = 1'b1;
    #1;
    chk({tag, "_c1_req"}, {31'd0, ram_req}, 32'd1);
    chk({tag, "_c1_addr"}, ram_addr, {a[31:2], 2'b00});
    chk({tag, "_c1_wstrb"}, {28'd0, ram_wstrb}, 32'd0);
    chk({tag, "_c1_we"}, {31'd0, ram_we}, 32'd0);
    cyc();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    #1;
    chk({tag, "_c2_req"}, {31'd0, ram_req}, 32'd0);
    chk({tag, "_c2_ready"}, {31'd0, ready_go_ex}, 32'd0);
    cyc();
    mem_data_ok = 1'b0;
    #1;
    chk({tag, "_c3_ready"}, {31'd0, ready_go_ex}, 32'd1);
    chk({tag, "_c3_data"}, load_data, exp);
    cyc();
    clr_op();
    #1;
    chk({tag, "_retire_busy"}, {31'd0, lsu_busy}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    valid_ex      = 1'b0;
    mem_read_ex   = 1'b0;
    mem_write_ex  = 1'b0;
    funct3_ex     = 3'd0;
    addr_ex       = 32'd0;
    store_data_ex = 32'd0;
    allow_in_wb   = 1'b1;
    mem_addr_ok   = 1'b0;
    mem_data_ok   = 1'b0;
    mem_rdata     = 32'd0;

    // reset state
    cyc();
    cyc();
    chk("rst_req", {31'd0, ram_req}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, ram_wstrb}, 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
    chk("rst_ready", {31'd0, ready_go_ex}, 32'd1);
    chk("rst_exc", {31'd0, mem_exc_ex}, 32'd0);
    rst_n = 1'b1;

    // loads, zero wait
    zero_wait_load("lw100", 3'b010, 32'h0000_0100, 32'h8765_4321, 32'h8765_4321);
    zero_wait_load("lb103", 3'b000, 32'h0000_0103, 32'h8012_3456, 32'hFFFF_FF80);
    zero_wait_load("lbu103", 3'b100, 32'h0000_0103, 32'h8012_3456, 32'h0000_0080);

    // SH at 0x202, addr_ok after two wait cycles; early data_ok is ignored
    cyc();
    set_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF);
    #1;
    chk("sh_c0_ready", {31'd0, ready_go_ex}, 32'd0);
    cyc();
    mem_data_ok = 1'b1;
    #1;
    chk("sh_w0_req", {31'd0, ram_req}, 32'd1);
    chk("sh_w0_addr", ram_addr, 32'h0000_0200);
    chk("sh_w0_wstrb", {28'd0, ram_wstrb}, 32'hC);
    chk("sh_w0_wdata", ram_wdata, 32'hBEEF_BEEF);
    chk("sh_w0_we", {31'd0, ram_we}, 32'd1);
    cyc();
    mem_data_ok = 1'b0;
    #1;
    chk("sh_w1_req", {31'd0, ram_req}, 32'd1);
    chk("sh_w1_wstrb", {28'd0, ram_wstrb}, 32'hC);
    chk("sh_w1_wdata", ram_wdata, 32'hBEEF_BEEF);
    cyc();
    mem_addr_ok = 1'b1;
    #1;
    chk("sh_w2_req", {31'd0, ram_req}, 32'd1);
    chk("sh_w2_addr", ram_addr, 32'h0000_0200);
    cyc();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    chk("sh_data_req", {31'd0, ram_req}, 32'd0);
    chk("sh_data_busy", {31'd0, lsu_busy}, 32'd1);
    cyc();
    mem_data_ok = 1'b0;
    #1;
    chk("sh_done_ready", {31'd0, ready_go_ex}, 32'd1);
    chk("sh_done_load", load_data, 32'h0000_0080);
    cyc();
    clr_op();
    #1;
    chk("sh_retire_busy", {31'd0, lsu_busy}, 32'd0);

    // SB at 0x001
    cyc();
    set_op(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5);
    cyc();
    mem_addr_ok = 1'b1;
    #1;
    chk("sb_wstrb", {28'd0, ram_wstrb}, 32'h2);
    chk("sb_wdata", ram_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", ram_addr, 32'h0000_0000);
    cyc();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    cyc();
    mem_data_ok = 1'b0;
    #1;
    chk("sb_done_ready", {31'd0, ready_go_ex}, 32'd1);
    cyc();
    clr_op();

    // exceptions: no request, ready immediately
    cyc();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0);
    #1;
    chk("lw101_exc", {31'd0, mem_exc_ex}, 32'd1);
    chk("lw101_ready", {31'd0, ready_go_ex}, 32'd1);
    chk("lw101_req0", {31'd0, ram_req}, 32'd0);
    cyc();
    #1;
    chk("lw101_req1", {31'd0, ram_req}, 32'd0);
    chk("lw101_busy1", {31'd0, lsu_busy}, 32'd0);
    set_op(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'd0);
    #1;
    chk("sh203_exc", {31'd0, mem_exc_ex}, 32'd1);
    set_op(1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'd0);
    #1;
    chk("sf3_100_exc", {31'd0, mem_exc_ex}, 32'd1);
    set_op(1'b1, 1'b0, 3'b011, 32'h0000_0200, 32'd0);
    #1;
    chk("lf3_011_exc", {31'd0, mem_exc_ex}, 32'd1);
    set_op(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'd0);
    #1;
    chk("rdwr_exc", {31'd0, mem_exc_ex}, 32'd1);
    cyc();
    #1;
    chk("exc_seq_req", {31'd0, ram_req}, 32'd0);
    chk("exc_seq_busy", {31'd0, lsu_busy}, 32'd0);
    // legal op flushed in IDLE never requests
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'd0);
    flush = 1'b1;
    #1;
    chk("flush_idle_exc", {31'd0, mem_exc_ex}, 32'd0);
    cyc();
    flush = 1'b0;
    clr_op();
    #1;
    chk("flush_idle_req", {31'd0, ram_req}, 32'd0);
    chk("flush_idle_busy", {31'd0, lsu_busy}, 32'd0);
    chk("no_op_exc", {31'd0, mem_exc_ex}, 32'd0);

    // flush in DATA, data_ok three cycles later is drained
    cyc();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
    cyc();
    mem_addr_ok = 1'b1;
    #1;
    chk("fl_req", {31'd0, ram_req}, 32'd1);
    cyc();
    mem_addr_ok = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_data_ready", {31'd0, ready_go_ex}, 32'd0);
    cyc();
    flush = 1'b0;
    clr_op();
    #1;
    chk("fl_drain_busy", {31'd0, lsu_busy}, 32'd1);
    chk("fl_drain_ready0", {31'd0, ready_go_ex}, 32'd0);
    chk("fl_drain_req", {31'd0, ram_req}, 32'd0);
    cyc();
    #1;
    chk("fl_drain_ready1", {31'd0, ready_go_ex}, 32'd0);
    cyc();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("fl_drain_ready2", {31'd0, ready_go_ex}, 32'd0);
    chk("fl_drain_busy2", {31'd0, lsu_busy}, 32'd1);
    cyc();
    mem_data_ok = 1'b0;
    #1;
    chk("fl_idle_busy", {31'd0, lsu_busy}, 32'd0);
    chk("fl_discard", load_data, 32'h0000_0080);
    zero_wait_load("lw104", 3'b010, 32'h0000_0104, 32'h1122_3344, 32'h1122_3344);

    // DONE held by WB for five cycles
    cyc();
    set_op(1'b1, 1'b0, 3'b001, 32'h0000_0106, 32'd0);
    allow_in_wb = 1'b0;
    cyc();
    mem_addr_ok = 1'b1;
    cyc();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h8001_5555;
    for (int i = 0; i < 5; i++) begin
      cyc();
      mem_data_ok = 1'b0;
      mem_rdata   = 32'd0;
      #1;
      chk($sformatf("hold%0d_ready", i), {31'd0, ready_go_ex}, 32'd1);
      chk($sformatf("hold%0d_load", i), load_data, 32'hFFFF_8001);
      chk($sformatf("hold%0d_req", i), {31'd0, ram_req}, 32'd0);
    end
    cyc();
    allow_in_wb = 1'b1;
    #1;
    chk("hold5_ready", {31'd0, ready_go_ex}, 32'd1);
    chk("hold5_busy", {31'd0, lsu_busy}, 32'd1);
    cyc();
    clr_op();
    #1;
    chk("hold_idle_busy", {31'd0, lsu_busy}, 32'd0);
    chk("hold_idle_load", load_data, 32'hFFFF_8001);

    // reset while in ADDR
    cyc();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0);
    cyc();
    #1;
    chk("rsta_req_before", {31'd0, ram_req}, 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    clr_op();
    #1;
    chk("rsta_req", {31'd0, ram_req}, 32'd0);
    chk("rsta_busy", {31'd0, lsu_busy}, 32'd0);
    chk("rsta_addr", ram_addr, 32'd0);
    chk("rsta_load", load_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ex.md
# lsu_ex

Load/store unit for the EX stage, directly downstream of the ID/EX pipeline register. It consumes the registered memory controls, operands and effective address of the instruction in EX, and runs the data-RAM request over a two-phase addr_ok/data_ok handshake. It returns byte-lane-aligned, sign/zero-extended load data and a ready_go_ex that holds the pipe until the access completes and WB accepts it.

## Interface
- No parameters; data/address width fixed at 32.
- clk  in  1  clock, all state on posedge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  kill the instruction in EX (trap/branch redirect)
- valid_ex  in  1  EX slot holds a valid instruction
- mem_read_ex / mem_write_ex  in  1 each  load / store (already gated by valid_ex upstream); both high is illegal and counts as an exception
- funct3_ex  in  3  access size/sign (instruction[14:12])
- addr_ex  in  32  effective address (rs1 + imm)
- store_data_ex  in  32  rs2 data
- allow_in_wb  in  1  WB can accept the EX result this cycle
- ram_req  out  1  request valid
- ram_we  out  1  1 = write
- ram_addr  out  32  word address ({addr[31:2],2'b00})
- ram_wdata  out  32  lane-replicated store data
- ram_wstrb  out  4  byte enables (0000 on reads)
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  read data / write ack valid this cycle
- mem_rdata  in  32  raw read word
- load_data  out  32  formatted load result
- ready_go_ex  out  1  EX may hand its result to WB
- mem_exc_ex  out  1  misaligned or illegal access; no RAM request issued
- lsu_busy  out  1  state != IDLE

## Operation
- States: IDLE, ADDR, DATA, DONE, DRAIN.
- IDLE
  - Memory op with valid_ex, no exception and no flush: latch addr, funct3, we, wstrb, wdata; go to ADDR.
  - No memory op: ready_go_ex = 1 combinationally.
  - Exception: mem_exc_ex = 1 and ready_go_ex = 1 combinationally; stay IDLE.
- ADDR: ram_req = 1, fields driven from the latches and held stable until mem_addr_ok.
  - mem_addr_ok -> DATA.
  - flush without mem_addr_ok -> IDLE; the request is dropped.
- DATA: wait for mem_data_ok. Capture the formatted rdata into load_data on reads; on writes, mem_data_ok is the ack.
  - mem_data_ok -> DONE, or -> IDLE if flush is high in that same cycle.
  - flush without mem_data_ok -> DRAIN.
- DRAIN: wait for mem_data_ok, discard the data, -> IDLE. ready_go_ex stays 0.
- DONE: ready_go_ex = 1.
  - allow_in_wb -> IDLE.
  - flush -> IDLE; flush wins.
- Store strobes by offset o = addr[1:0]:
  - SB (000): 0001<<o, wdata = {4{b}}.
  - SH (001): 0011<<o, wdata = {2{h}}.
  - SW (010): 1111, wdata = data.
- Load formatting: select the byte/half at offset o.
  - LB (000) / LH (001): sign-extend.
  - LBU (100) / LHU (101): zero-extend.
  - LW (010): pass the full word.
- Exception conditions:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - funct3 011/110/111, or any store funct3 >= 011.
  - mem_read_ex & mem_write_ex.
- ram_req is never asserted for a faulting or flushed-in-IDLE access.

## Timing
- Reset: state IDLE; ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb, load_data = 0; ready_go_ex and mem_exc_ex follow IDLE rules (0 while valid_ex = 0 is irrelevant). Reset mid-access returns to IDLE next edge with no drain; the memory side is reset by the same rst_n.
- Best-case memory op, counting from the cycle the op is seen in IDLE as cycle 0:
  - cycle 1: ram_req with mem_addr_ok.
  - cycle 2: mem_data_ok.
  - cycle 3: DONE, ready_go_ex = 1.
  - Retires at cycle 3 if allow_in_wb = 1, i.e. 4 cycles in EX.
- Each wait cycle on mem_addr_ok or mem_data_ok adds one cycle.
- load_data is stable from DONE entry until the next access is captured.
- allow_in_wb = 0 in DONE holds DONE indefinitely; no new request is issued.
- mem_data_ok arriving in ADDR is a protocol error and is ignored.

## Test plan
- LW at addr 0x100, rdata 0x8765_4321, addr_ok and data_ok with zero wait -> ram_req for one cycle, ram_addr 0x100, wstrb 0000; load_data 0x8765_4321; ready_go_ex at cycle 3.
- LB at 0x103, then LBU at 0x103, rdata 0x80xx_xxxx -> load_data 0xFFFF_FF80, then 0x0000_0080.
- SH at 0x202, data 0x0000_BEEF, addr_ok delayed 2 cycles -> ram_req held for 3 cycles with stable fields: addr 0x200, wstrb 1100, wdata 0xBEEF_BEEF, we = 1.
- LW at 0x101 -> mem_exc_ex = 1, ready_go_ex = 1, ram_req never asserted.
- flush while in DATA, data_ok 3 cycles later -> DRAIN; the data is discarded, ready_go_ex stays 0, return to IDLE; the following LW issues normally.
- DONE with allow_in_wb = 0 for 5 cycles, then 1 -> ready_go_ex held for 6 cycles, load_data stable, IDLE after the last one; rst_n low while in ADDR -> ram_req = 0 and IDLE on the next edge.
